// File: rtl/notch_biquad_tdm.sv
// notch_biquad_tdm: direct-form-I biquad IIR, time-multiplexed over CH
// channels with per-channel x/y history and a single shared multiplier.
//   y = sat_W(round((b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2) >>> (CW-2)))
// Optional build macro: NOTCH_OVF_FLAG_EN adds a sticky `ovf` output that
// records any sample whose pre-saturation value left the W-bit range.
module notch_biquad_tdm #(
    parameter int W   = 16,
    parameter int CW  = 16,
    parameter int CH  = 4,
    parameter int CHW = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    input  logic [CHW-1:0] in_ch,
    input  logic [CW-1:0]  coef_b0,
    input  logic [CW-1:0]  coef_b1,
    input  logic [CW-1:0]  coef_b2,
    input  logic [CW-1:0]  coef_a1,
    input  logic [CW-1:0]  coef_a2,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic [CHW-1:0] out_ch
`ifdef NOTCH_OVF_FLAG_EN
    ,
    output logic           ovf
`endif
);

    localparam int AW    = W + CW + 3;   // accumulator, cannot overflow
    localparam int PW    = W + CW + 1;   // product, room for negation
    localparam int DEPTH = 1 << CHW;
    localparam logic [2:0] LAST_TAP = 3'd5;  // tap slot that forms y

    localparam logic signed [AW-1:0] ROUND =
        {{(AW-CW+2){1'b0}}, 1'b1, {(CW-3){1'b0}}};
    localparam logic signed [AW-1:0] SAT_MAX =
        {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN =
        {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    state_t state_q, state_d;
    logic   run_q;
    logic   accept;
    logic   chan_ok;

    // Captured sample, channel and coefficients for the sample in flight.
    logic signed [W-1:0]  x_q;
    logic [CHW-1:0]       ch_q;
    logic                 drop_q;
    logic signed [CW-1:0] b0_q, b1_q, b2_q, a1_q, a2_q;

    // Shared multiplier / accumulator.
    logic [2:0]           tap_q;
    logic signed [CW-1:0] coef_sel;
    logic signed [W-1:0]  samp_sel;
    logic                 neg_sel;
    logic signed [PW-1:0] prod_raw, prod_sel, prod_q;
    logic signed [AW-1:0] acc_q, prod_ext, sum_full, shifted;
    logic                 over, under;
    logic signed [W-1:0]  y_sat;

    // Per-channel history; entries at or above CH are never written.
    logic signed [W-1:0] x1_mem [DEPTH];
    logic signed [W-1:0] x2_mem [DEPTH];
    logic signed [W-1:0] y1_mem [DEPTH];
    logic signed [W-1:0] y2_mem [DEPTH];

    assign chan_ok = ({1'b0, in_ch} < (CHW+1)'(CH));
    assign accept  = in_valid && in_ready;

    // State register; run_q holds in_ready low until the first edge after reset release.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    // Next-state and handshake outputs.
    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = rst_n && run_q;
                if (in_valid && rst_n && run_q) state_d = S_MAC;
            end
            S_MAC: begin
                if (drop_q)                  state_d = S_IDLE;
                else if (tap_q == LAST_TAP)  state_d = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operand select for the current tap; feedback terms are negated.
    always_comb begin
        coef_sel = b0_q;
        samp_sel = x_q;
        neg_sel  = 1'b0;
        case (tap_q)
            3'd1: begin coef_sel = b1_q; samp_sel = x1_mem[ch_q]; end
            3'd2: begin coef_sel = b2_q; samp_sel = x2_mem[ch_q]; end
            3'd3: begin coef_sel = a1_q; samp_sel = y1_mem[ch_q]; neg_sel = 1'b1; end
            3'd4: begin coef_sel = a2_q; samp_sel = y2_mem[ch_q]; neg_sel = 1'b1; end
            default: ;
        endcase
        prod_raw = PW'(coef_sel) * PW'(samp_sel);
        prod_sel = neg_sel ? -prod_raw : prod_raw;
    end

    // Final sum, rounding, arithmetic shift back to sample scale, saturation.
    always_comb begin
        prod_ext = {{(AW-PW){prod_q[PW-1]}}, prod_q};
        sum_full = acc_q + prod_ext + ROUND;
        shifted  = sum_full >>> (CW-2);
        over     = shifted > SAT_MAX;
        under    = shifted < SAT_MIN;
        if (over)       y_sat = SAT_MAX[W-1:0];
        else if (under) y_sat = SAT_MIN[W-1:0];
        else            y_sat = shifted[W-1:0];
    end

    // Datapath: capture at accept, pipelined multiply-accumulate, output hold, history update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: history must restart from zero, so the memories are cleared explicitly in reset.
            for (int i = 0; i < DEPTH; i++) begin
                x1_mem[i] <= '0;
                x2_mem[i] <= '0;
                y1_mem[i] <= '0;
                y2_mem[i] <= '0;
            end
            x_q      <= '0;
            ch_q     <= '0;
            drop_q   <= 1'b0;
            b0_q     <= '0;
            b1_q     <= '0;
            b2_q     <= '0;
            a1_q     <= '0;
            a2_q     <= '0;
            tap_q    <= '0;
            prod_q   <= '0;
            acc_q    <= '0;
            out_data <= '0;
            out_ch   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        x_q    <= in_data;
                        ch_q   <= in_ch;
                        drop_q <= !chan_ok;
                        b0_q   <= coef_b0;
                        b1_q   <= coef_b1;
                        b2_q   <= coef_b2;
                        a1_q   <= coef_a1;
                        a2_q   <= coef_a2;
                        tap_q  <= '0;
                        acc_q  <= '0;
                    end
                end
                S_MAC: begin
                    if (!drop_q) begin
                        // Product registered in slot t is accumulated in slot t+1.
                        if (tap_q != LAST_TAP) begin
                            prod_q <= prod_sel;
                            tap_q  <= tap_q + 3'd1;
                        end
                        if (tap_q != 3'd0) acc_q <= acc_q + prod_ext;
                        if (tap_q == LAST_TAP) begin
                            out_data <= y_sat;
                            out_ch   <= ch_q;
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        x2_mem[ch_q] <= x1_mem[ch_q];
                        x1_mem[ch_q] <= x_q;
                        y2_mem[ch_q] <= y1_mem[ch_q];
                        y1_mem[ch_q] <= out_data;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef NOTCH_OVF_FLAG_EN
    logic ovf_pend_q;
    logic ovf_q;

    // Remember the range violation when y is formed; make it sticky on the output handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            if (state_q == S_MAC && !drop_q && tap_q == LAST_TAP)
                ovf_pend_q <= over || under;
            if (state_q == S_OUT && out_ready && ovf_pend_q)
                ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    // Without the flag, over/under only steer the saturation mux.
`endif

endmodule

// File: tb/tb_notch_biquad_tdm.sv
// tb_notch_biquad_tdm: scoreboard bench for notch_biquad_tdm. The driver
// pushes expected outputs from an arithmetic model of the filter equation;
// a negedge monitor pops and compares on every output handshake and checks
// the accept-to-out_valid latency.
`timescale 1ns/1ps
module tb_notch_biquad_tdm;

    localparam int W   = 16;
    localparam int CW  = 16;
    localparam int CH  = 4;
    localparam int CHW = 3;   // wide enough to present channels >= CH

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_data = '0;
    logic [CHW-1:0] in_ch = '0;
    logic [CW-1:0]  coef_b0 = '0, coef_b1 = '0, coef_b2 = '0, coef_a1 = '0, coef_a2 = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [W-1:0]   out_data;
    logic [CHW-1:0] out_ch;
`ifdef NOTCH_OVF_FLAG_EN
    logic           ovf;
`endif

    notch_biquad_tdm #(.W(W), .CW(CW), .CH(CH), .CHW(CHW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_ch    (in_ch),
        .coef_b0  (coef_b0),
        .coef_b1  (coef_b1),
        .coef_b2  (coef_b2),
        .coef_a1  (coef_a1),
        .coef_a2  (coef_a2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ch   (out_ch)
`ifdef NOTCH_OVF_FLAG_EN
        ,
        .ovf      (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int data;
    } exp_t;

    exp_t exp_q[$];
    int   lat_q[$];
    int   checks = 0;
    int   failures = 0;
    int   nidx = 0;
    logic ov_prev = 1'b0;
    bit   rand_rdy = 1'b0;

    // Reference model state: coefficients as signed integers, history per channel.
    int cb0, cb1, cb2, ca1, ca2;
    int mx1[CH], mx2[CH], my1[CH], my2[CH];
    bit mov;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_coefs(input int b0, input int b1, input int b2, input int a1, input int a2);
        cb0 = b0; cb1 = b1; cb2 = b2; ca1 = a1; ca2 = a2;
    endtask

    // y = sat(round((b0 x + b1 x1 + b2 x2 - a1 y1 - a2 y2) / 2^(CW-2)))
    function automatic void model_push(input int ch, input int x);
        longint acc, r;
        int     y;
        exp_t   e;
        acc = longint'(cb0) * x + longint'(cb1) * mx1[ch] + longint'(cb2) * mx2[ch]
            - longint'(ca1) * my1[ch] - longint'(ca2) * my2[ch];
        r = (acc + (longint'(1) <<< (CW-3))) >>> (CW-2);
        if (r > (longint'(1) <<< (W-1)) - 1) y = (1 <<< (W-1)) - 1;
        else if (r < -(longint'(1) <<< (W-1))) y = -(1 <<< (W-1));
        else y = int'(r);
        if (longint'(y) != r) mov = 1'b1;
        mx2[ch] = mx1[ch];
        mx1[ch] = x;
        my2[ch] = my1[ch];
        my1[ch] = y;
        e.ch = ch;
        e.data = y;
        exp_q.push_back(e);
    endfunction

    task automatic send(input int ch, input int x);
        int waited = 0;
        while (in_ready !== 1'b1 && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (in_ready !== 1'b1) begin
            check("in_ready_wait", longint'(in_ready === 1'b1), 1);
            return;
        end
        in_valid = 1'b1;
        in_data  = W'(x);
        in_ch    = CHW'(ch);
        coef_b0  = CW'(cb0);
        coef_b1  = CW'(cb1);
        coef_b2  = CW'(cb2);
        coef_a1  = CW'(ca1);
        coef_a2  = CW'(ca2);
        if (ch < CH) model_push(ch, x);
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Coefficients may move freely once the sample is captured.
        coef_b0 = CW'($urandom);
        coef_b1 = CW'($urandom);
        coef_b2 = CW'($urandom);
        coef_a1 = CW'($urandom);
        coef_a2 = CW'($urandom);
        in_data = W'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || in_ready !== 1'b1) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_done", longint'(n < 500), 1);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_in_ready", in_ready, 0);
        for (int i = 0; i < CH; i++) begin
            mx1[i] = 0; mx2[i] = 0; my1[i] = 0; my2[i] = 0;
        end
        exp_q.delete();
        lat_q.delete();
        mov = 1'b0;
        rst_n = 1'b1;
        #1;
        check("in_ready_before_first_edge", in_ready, 0);
        @(posedge clk); #1;
        check("in_ready_after_release", in_ready, 1);
`ifdef NOTCH_OVF_FLAG_EN
        check("ovf_after_reset", ovf, 0);
`endif
    endtask

    // Monitor: latency on out_valid rise, scoreboard compare on handshake.
    always @(negedge clk) begin
        exp_t e;
        nidx++;
        if (!rst_n) begin
            exp_q.delete();
            lat_q.delete();
            check("in_ready_in_reset", in_ready, 0);
        end else begin
            if (in_valid && in_ready && in_ch < CH) lat_q.push_back(nidx);
            if (out_valid && !ov_prev) begin
                check("out_valid_has_accept", lat_q.size() > 0, 1);
                // Accept is seen one negedge before the accepting edge.
                if (lat_q.size() > 0) check("latency_edges", nidx - lat_q.pop_front() - 1, 6);
            end
            if (out_valid && out_ready) begin
                check("output_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("out_ch", out_ch, e.ch);
                    check("out_data", $signed(out_data), e.data);
                end
            end
        end
        ov_prev = out_valid;
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_n;
        int ch;
        do_reset();

        // Pass-through, including both full-scale extremes.
        set_coefs(16384, 0, 0, 0, 0);
        send(0, 100);
        send(1, -200);
        send(2, 32767);
        send(3, -32768);
        drain();

        // DC blocker on ch1 with an interleaved ch2 sample.
        do_reset();
        set_coefs(16384, -16384, 0, 0, 0);
        send(1, 500);
        send(1, 500);
        send(2, 7);
        send(1, 500);
        send(1, 500);
        drain();

        // Recursion: impulse decays by half each sample.
        do_reset();
        set_coefs(16384, 0, 0, -8192, 0);
        send(0, 1000);
        repeat (3) send(0, 0);
        drain();

        // Saturation both ways.
        do_reset();
        set_coefs(32767, 0, 0, 0, 0);
        send(3, 30000);
        drain();
`ifdef NOTCH_OVF_FLAG_EN
        check("ovf_set", ovf, 1);
`endif
        send(3, -30000);
        drain();

        // Backpressure: output held, then history advanced exactly once.
        do_reset();
        set_coefs(16384, 0, 16384, 0, 0);
        out_ready = 1'b0;
        send(0, 123);
        wait_n = 0;
        while (out_valid !== 1'b1 && wait_n < 50) begin
            @(posedge clk); #1;
            wait_n++;
        end
        check("bp_out_valid_seen", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data", $signed(out_data), 123);
            check("bp_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();
        send(0, 50);
        send(0, 60);
        drain();

        // Reset during tap 3 of a sample with non-zero history.
        do_reset();
        set_coefs(16384, 8192, 0, -8192, 0);
        send(0, 1000);
        drain();
        send(0, 400);
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        send(0, 777);
        drain();

        // Out-of-range channel: no output, history untouched.
        send(5, 1234);
        send(0, -321);
        drain();

        // Randomized traffic with random backpressure and coefficient changes.
        do_reset();
        rand_rdy = 1'b1;
        for (int n = 0; n < 150; n++) begin
            if (n % 10 == 0)
                set_coefs($signed(CW'($urandom)), $signed(CW'($urandom)), $signed(CW'($urandom)),
                          $signed(CW'($urandom)), $signed(CW'($urandom)));
            if ($urandom_range(0, 9) == 0) ch = $urandom_range(CH, 7);
            else ch = $urandom_range(0, CH - 1);
            send(ch, $signed(W'($urandom)));
        end
        rand_rdy = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        drain();
`ifdef NOTCH_OVF_FLAG_EN
        check("ovf_random", ovf, longint'(mov));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
